// File: rtl/smaesh_out_serializer_if.sv
// rtl/smaesh_out_serializer_if.sv - ciphertext-in / 32-bit-word-out handshake bundle for the output serializer
interface smaesh_out_serializer_if #(
    parameter int D = 2
);
    logic [128*D-1:0] in_shares_data;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;

    // Producer of ciphertexts and consumer of words (the surrounding system)
    modport master (
        output in_shares_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );

    // The serializer itself
    modport slave (
        input  in_shares_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/smaesh_out_serializer.sv
// rtl/smaesh_out_serializer.sv - serializes a 128*D-bit shared ciphertext into zeroized 32-bit words
module smaesh_out_serializer #(
    parameter int D = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    smaesh_out_serializer_if.slave        bus_io
);
    localparam int NW = 4 * D;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic {
        ST_EMPTY,
        ST_SENDING
    } state_e;

    state_e           state_q, state_d;
    logic [128*D-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             sending;
    logic             last_word;
    logic             word_xfer;
    logic             in_xfer;
    logic [31:0]      cur_word;

    assign sending   = (state_q == ST_SENDING);
    assign last_word = sending && (cnt_q == CW'(NW - 1));
    assign word_xfer = sending && bus_io.out_ready;
    // Accept a new block while empty, or in the same cycle the final word leaves
    assign in_xfer   = bus_io.in_valid && bus_io.in_ready;

    assign bus_io.in_ready  = !sending || (last_word && bus_io.out_ready);
    assign bus_io.out_valid = sending;
    assign bus_io.busy      = sending;
    assign bus_io.out_last  = last_word;
    assign bus_io.out_data  = cur_word;

    // Select the word at the current index; hold is all-zero when empty so this reads 0
    always_comb begin
        cur_word = '0;
        for (int w = 0; w < NW; w++) begin
            if (cnt_q == CW'(w)) begin
                cur_word = hold_q[32*w +: 32];
            end
        end
    end

    // Next state: wipe each word as it transfers, advance, and reload on capture
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;

        if (word_xfer) begin
            for (int w = 0; w < NW; w++) begin
                if (cnt_q == CW'(w)) begin
                    hold_d[32*w +: 32] = '0;
                end
            end
            if (last_word) begin
                state_d = ST_EMPTY;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // A capture overrides the return to EMPTY, giving zero-bubble back-to-back blocks
        if (in_xfer) begin
            hold_d  = bus_io.in_shares_data;
            cnt_d   = '0;
            state_d = ST_SENDING;
        end
    end

    // State register; reset discards any partially sent block
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_smaesh_out_serializer.sv
// tb/tb_smaesh_out_serializer.sv - directed self-checking bench for smaesh_out_serializer
module tb_smaesh_out_serializer;
    localparam int D  = 2;
    localparam int NW = 4 * D;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    smaesh_out_serializer_if #(.D(D)) bus ();

    smaesh_out_serializer #(.D(D)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_a(input int w);
        return 32'h1111_1111 * w;
    endfunction

    function automatic logic [31:0] word_b(input int w);
        return 32'hC0DE_0100 + w;
    endfunction

    function automatic logic [255:0] block_a();
        logic [255:0] b;
        for (int w = 0; w < NW; w++) b[32*w +: 32] = word_a(w);
        return b;
    endfunction

    function automatic logic [255:0] block_b();
        logic [255:0] b;
        for (int w = 0; w < NW; w++) b[32*w +: 32] = word_b(w);
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [255:0] blk);
        bus.in_shares_data = blk;
        bus.in_valid       = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_in_ready got=%b exp=1", bus.in_ready);
        end
        step();
        bus.in_valid       = 1'b0;
        bus.in_shares_data = '1;
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_shares_data = '0;
        bus.out_ready      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_last, bus.busy, bus.in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_flags got v/l/b/r=%b%b%b%b exp=0001",
                     bus.out_valid, bus.out_last, bus.busy, bus.in_ready);
        end
        checks++;
        if (bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=00000000", bus.out_data);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got v=%b r=%b exp v=0 r=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        load(block_a());
        for (int w = 0; w < NW; w++) begin
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== word_a(w)) begin
                errors++;
                $display("FAIL stream_word%0d got v=%b d=%h exp v=1 d=%h",
                         w, bus.out_valid, bus.out_data, word_a(w));
            end
            checks++;
            if (bus.out_last !== (w == NW - 1)) begin
                errors++;
                $display("FAIL stream_last%0d got=%b exp=%b", w, bus.out_last, (w == NW - 1));
            end
            step();
            checks++;
            if (dut.hold_q[32*w +: 32] !== 32'h0) begin
                errors++;
                $display("FAIL zeroize_word%0d got=%h exp=00000000", w, dut.hold_q[32*w +: 32]);
            end
        end
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL stream_idle got v=%b d=%h exp v=0 d=00000000", bus.out_valid, bus.out_data);
        end
        checks++;
        if (dut.hold_q !== '0) begin
            errors++;
            $display("FAIL zeroize_all got=%h exp=0", dut.hold_q);
        end
    endtask

    task automatic test_stall();
        int   idx;
        logic r;
        idx = 0;
        r   = 1'b1;
        bus.out_ready = 1'b1;
        load(block_a());
        for (int cyc = 0; cyc < 40 && idx < NW; cyc++) begin
            bus.out_ready = r;
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== word_a(idx)
                || bus.out_last !== (idx == NW - 1)) begin
                errors++;
                $display("FAIL stall_cyc%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         cyc, bus.out_valid, bus.out_data, bus.out_last, word_a(idx), (idx == NW - 1));
            end
            if (r) idx++;
            r = ~r;
            step();
        end
        checks++;
        if (idx !== NW) begin
            errors++;
            $display("FAIL stall_count got=%0d exp=%0d", idx, NW);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle got v=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        bus.out_ready = 1'b1;
        load(block_a());
        bus.in_shares_data = block_b();
        bus.in_valid       = 1'b1;
        for (int k = 0; k < 2 * NW; k++) begin
            exp_d = (k < NW) ? word_a(k) : word_b(k - NW);
            if (k == NW - 1) begin
                bus.out_ready = 1'b0;
                #1;
                checks++;
                if (bus.in_ready !== 1'b0 || bus.out_last !== 1'b1 || bus.out_data !== exp_d) begin
                    errors++;
                    $display("FAIL b2b_stalled_last got r=%b l=%b d=%h exp r=0 l=1 d=%h",
                             bus.in_ready, bus.out_last, bus.out_data, exp_d);
                end
                step();
                bus.out_ready = 1'b1;
            end
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) begin
                errors++;
                $display("FAIL b2b_word%0d got v=%b d=%h exp v=1 d=%h", k, bus.out_valid, bus.out_data, exp_d);
            end
            checks++;
            if (bus.out_last !== (k % NW == NW - 1)
                || bus.in_ready !== (k % NW == NW - 1)) begin
                errors++;
                $display("FAIL b2b_flags%0d got l=%b r=%b exp l=%b r=%b",
                         k, bus.out_last, bus.in_ready, (k % NW == NW - 1), (k % NW == NW - 1));
            end
            step();
            if (k == NW - 1) begin
                bus.in_valid       = 1'b0;
                bus.in_shares_data = '1;
            end
        end
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL b2b_idle got v=%b d=%h exp v=0 d=00000000", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b1;
        load(block_a());
        repeat (4) step();
        #1;
        checks++;
        if (bus.out_data !== word_a(4)) begin
            errors++;
            $display("FAIL arst_pre got=%h exp=%h", bus.out_data, word_a(4));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_now got v=%b d=%h b=%b exp v=0 d=00000000 b=0",
                     bus.out_valid, bus.out_data, bus.busy);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_release got r=%b v=%b exp r=1 v=0", bus.in_ready, bus.out_valid);
        end
        step();
        load(block_b());
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== word_b(0) || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL arst_restart got v=%b d=%h l=%b exp v=1 d=%h l=0",
                     bus.out_valid, bus.out_data, bus.out_last, word_b(0));
        end
        repeat (NW) step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
